vga_dual_bank_ram: RTL and testbench

//  Parametrised double-buffered VGA pixel RAM: wide-word writes from the CPU/blitter side, narrow pixel reads on the scan-out side.
//  Two identical banks: writes always target the back bank; reads always target the front bank.

---
 rtl/vga_ram_pkg.sv | 29 ++
 rtl/vga_ram_bank.sv | 53 +++++
 rtl/vga_dual_bank_ram.sv | 199 +++++++++++++++++++
 tb/tb_vga_dual_bank_ram.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_ram_pkg.sv
// vga_ram_pkg
//   Shared definitions for the double-buffered VGA pixel RAM.
//   - clog2       : constant function for deriving address widths
//   - SWAP_IDLE,
//     SWAP_PENDING: bank-swap FSM state encoding
//   - LANE0_LSB   : lane 0 of a write word occupies the least-significant bits
package vga_ram_pkg;

  // Number of bits needed to address 'value' entries (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Swap FSM state encoding.
  localparam logic [0:0] SWAP_IDLE    = 1'b0;
  localparam logic [0:0] SWAP_PENDING = 1'b1;

  // Pixel lane ordering inside a write word: lane 0 sits in the LSBs.
  localparam bit LANE0_LSB = 1'b1;

endpackage : vga_ram_pkg

// File: rtl/vga_ram_bank.sv
// vga_ram_bank
//   One pixel bank: an inferred simple dual-port RAM with a wide write port
//   carrying per-lane write enables and a registered wide read port.
//   Each lane is stored in its own array so the lane enables map directly
//   onto independent RAM write enables.
// Ports
//   clk         in   1             clock for both ports
//   wr_en       in   1             write strobe
//   wr_addr     in   AW            write word address
//   wr_data     in   LANE_W*LANES  write word; lane k = [k*LANE_W +: LANE_W]
//   wr_lane_en  in   LANES         per-lane write enable
//   rd_en       in   1             read strobe; rd_data updates on the next edge
//   rd_addr     in   AW            read word address
//   rd_data     out  LANE_W*LANES  registered read word; holds when rd_en=0
module vga_ram_bank import vga_ram_pkg::*; #(
  parameter  int LANE_W = 8,
  parameter  int LANES  = 4,
  parameter  int DEPTH  = 64,
  localparam int AW     = clog2(DEPTH),
  localparam int W      = LANE_W * LANES
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [LANES-1:0] wr_lane_en,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [W-1:0]     rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] mem [DEPTH];
      logic [LANE_W-1:0] rd_lane_reg;

      // RAM contents and the RAM output register carry no reset so the
      // array maps onto block RAM.
      always_ff @(posedge clk) begin
        if (wr_en && wr_lane_en[gi]) begin
          mem[wr_addr] <= wr_data[gi*LANE_W +: LANE_W];
        end
        if (rd_en) begin
          rd_lane_reg <= mem[rd_addr];
        end
      end

      assign rd_data[gi*LANE_W +: LANE_W] = rd_lane_reg;
    end
  endgenerate

endmodule : vga_ram_bank

// File: rtl/vga_dual_bank_ram.sv
// vga_dual_bank_ram
//   Double-buffered VGA pixel RAM. Wide-word writes always land in the back
//   bank, narrow pixel reads always come from the front bank. A swap request
//   is held until the next frame_start strobe so the displayed frame never
//   tears.
// Ports
//   clk          in   1         single clock
//   rst_n        in   1         asynchronous active-low reset
//   wr_en        in   1         write strobe into the back bank
//   wr_addr      in   WR_AW     write word address
//   wr_data      in   WR_WIDTH  write data; lane k = [k*RD_WIDTH +: RD_WIDTH]
//   wr_lane_en   in   R         per-lane write enable
//   rd_en        in   1         pixel read strobe from the front bank
//   rd_addr      in   RD_AW     pixel address: upper bits word, low log2(R) bits lane
//   rd_data      out  RD_WIDTH  pixel data
//   rd_valid     out  1         rd_data belongs to the read issued LAT cycles ago
//   swap_req     in   1         bank swap request pulse
//   frame_start  in   1         frame boundary pulse
//   swap_pending out  1         swap requested, waiting for frame_start
//   front_bank   out  1         bank currently being read
// Build option
//   VGA_DUAL_BANK_RAM_OUT_REG_EN : adds an output register stage (LAT=2);
//                                  undefined gives LAT=1.
// R = WR_WIDTH/RD_WIDTH must be a power of two of at least 2.
module vga_dual_bank_ram import vga_ram_pkg::*; #(
  parameter  int WR_WIDTH = 32,
  parameter  int RD_WIDTH = 8,
  parameter  int WR_DEPTH = 64,
  localparam int R        = WR_WIDTH / RD_WIDTH,
  localparam int RD_DEPTH = WR_DEPTH * R,
  localparam int WR_AW    = clog2(WR_DEPTH),
  localparam int RD_AW    = clog2(RD_DEPTH),
  localparam int LANE_AW  = clog2(R)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [WR_AW-1:0]    wr_addr,
  input  logic [WR_WIDTH-1:0] wr_data,
  input  logic [R-1:0]        wr_lane_en,
  input  logic                rd_en,
  input  logic [RD_AW-1:0]    rd_addr,
  output logic [RD_WIDTH-1:0] rd_data,
  output logic                rd_valid,
  input  logic                swap_req,
  input  logic                frame_start,
  output logic                swap_pending,
  output logic                front_bank
);

  // ---------------------------------------------------------------------
  // Swap FSM
  // ---------------------------------------------------------------------
  logic [0:0] swap_state_reg, swap_state_next;
  logic       front_bank_reg, front_bank_next;

  always_comb begin
    swap_state_next = swap_state_reg;
    front_bank_next = front_bank_reg;
    case (swap_state_reg)
      SWAP_IDLE: begin
        if (swap_req && frame_start) begin
          // Request coincides with the boundary: apply it right away.
          front_bank_next = ~front_bank_reg;
        end else if (swap_req) begin
          swap_state_next = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        // Further swap_req pulses merge into the one already pending.
        if (frame_start) begin
          front_bank_next = ~front_bank_reg;
          swap_state_next = SWAP_IDLE;
        end
      end
      default: begin
        swap_state_next = SWAP_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_state_reg <= SWAP_IDLE;
      front_bank_reg <= 1'b0;
    end else begin
      swap_state_reg <= swap_state_next;
      front_bank_reg <= front_bank_next;
    end
  end

  assign swap_pending = (swap_state_reg == SWAP_PENDING);
  assign front_bank   = front_bank_reg;

  // ---------------------------------------------------------------------
  // Banks. Both ports steer on the registered front_bank, so on a swap edge
  // reads and writes still use the pre-swap assignment and the two ports
  // can never touch the same bank in one cycle.
  // ---------------------------------------------------------------------
  logic [WR_WIDTH-1:0] bank_rd_word [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic bank_is_front;
      assign bank_is_front = (front_bank_reg == 1'(gi));

      vga_ram_bank #(
        .LANE_W (RD_WIDTH),
        .LANES  (R),
        .DEPTH  (WR_DEPTH)
      ) u_bank (
        .clk        (clk),
        .wr_en      (wr_en & ~bank_is_front),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_lane_en (wr_lane_en),
        .rd_en      (rd_en & bank_is_front),
        .rd_addr    (rd_addr[RD_AW-1:LANE_AW]),
        .rd_data    (bank_rd_word[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Read side stage 1: remember which bank and lane the RAM output belongs
  // to. rd_loaded_reg forces rd_data to 0 after reset until the first read,
  // since the RAM output register itself is not reset.
  // ---------------------------------------------------------------------
  logic               rd_valid_s1_reg;
  logic               rd_bank_reg;
  logic               rd_loaded_reg;
  logic [LANE_AW-1:0] rd_lane_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_s1_reg <= 1'b0;
      rd_bank_reg     <= 1'b0;
      rd_loaded_reg   <= 1'b0;
      rd_lane_reg     <= '0;
    end else begin
      rd_valid_s1_reg <= rd_en;
      if (rd_en) begin
        rd_bank_reg   <= front_bank_reg;
        rd_lane_reg   <= rd_addr[LANE_AW-1:0];
        rd_loaded_reg <= 1'b1;
      end
    end
  end

  // Bank mux followed by lane select.
  logic [WR_WIDTH-1:0] rd_word_sel;
  logic [RD_WIDTH-1:0] rd_lanes [R];
  logic [LANE_AW-1:0]  lane_idx;
  logic [RD_WIDTH-1:0] rd_data_s1;

  assign rd_word_sel = bank_rd_word[rd_bank_reg];

  generate
    for (gi = 0; gi < R; gi++) begin : g_lane_split
      assign rd_lanes[gi] = rd_word_sel[gi*RD_WIDTH +: RD_WIDTH];
    end
  endgenerate

  always_comb begin
    lane_idx   = LANE0_LSB ? rd_lane_reg : (LANE_AW'(R - 1) - rd_lane_reg);
    rd_data_s1 = '0;
    if (rd_loaded_reg) begin
      rd_data_s1 = rd_lanes[lane_idx];
    end
  end

  // ---------------------------------------------------------------------
  // Optional output register stage
  // ---------------------------------------------------------------------
`ifdef VGA_DUAL_BANK_RAM_OUT_REG_EN
  logic [RD_WIDTH-1:0] rd_data_s2_reg;
  logic                rd_valid_s2_reg;

  // Copying every cycle keeps the hold behaviour: stage 1 itself holds when
  // no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_s2_reg  <= '0;
      rd_valid_s2_reg <= 1'b0;
    end else begin
      rd_data_s2_reg  <= rd_data_s1;
      rd_valid_s2_reg <= rd_valid_s1_reg;
    end
  end

  assign rd_data  = rd_data_s2_reg;
  assign rd_valid = rd_valid_s2_reg;
`else
  assign rd_data  = rd_data_s1;
  assign rd_valid = rd_valid_s1_reg;
`endif

endmodule : vga_dual_bank_ram

// File: tb/tb_vga_dual_bank_ram.sv
// tb_vga_dual_bank_ram
//   Scoreboard bench for vga_dual_bank_ram (default parameters 32/8/64).
//   Stimulus pushes expected pixels into a queue; a negedge monitor pops and
//   compares data and latency whenever rd_valid is high. Bank/swap state is
//   checked directly by the stimulus process.
module tb_vga_dual_bank_ram;

`ifdef VGA_DUAL_BANK_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_lane_en;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        swap_req;
  logic        frame_start;
  logic        swap_pending;
  logic        front_bank;

  vga_dual_bank_ram #(
    .WR_WIDTH (32),
    .RD_WIDTH (8),
    .WR_DEPTH (64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_lane_en   (wr_lane_en),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .swap_req     (swap_req),
    .frame_start  (frame_start),
    .swap_pending (swap_pending),
    .front_bank   (front_bank)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] addr;
    int         edge_cyc;
  } sb_t;
  sb_t sb_q[$];

  // Bench-side model of bank contents and of which bank is front.
  logic [31:0] tb_mem [2][64];
  logic        tb_front;
  logic [7:0]  last_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_lane_en = '0;
    rd_en = 1'b0; rd_addr = '0; swap_req = 1'b0; frame_start = 1'b0;
  endtask

  // Drive a write for the coming edge and update the model's back bank.
  task automatic set_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] le);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_lane_en = le;
    for (int k = 0; k < 4; k++)
      if (le[k]) tb_mem[~tb_front][a][k*8 +: 8] = d[k*8 +: 8];
  endtask

  // Drive a read for the coming edge and push the given expected pixel.
  task automatic set_read(input logic [7:0] a, input logic [7:0] exp);
    sb_t e;
    rd_en = 1'b1; rd_addr = a;
    e.data = exp; e.addr = a; e.edge_cyc = cycle_cnt + 1;
    sb_q.push_back(e);
    last_exp = exp;
  endtask

  function automatic logic [7:0] model_px(input logic [7:0] a);
    logic [31:0] w;
    w = tb_mem[tb_front][a[7:2]];
    return w[a[1:0]*8 +: 8];
  endfunction

  task automatic write_word(input logic [5:0] a, input logic [31:0] d, input logic [3:0] le);
    set_write(a, d, le);
    tick();
    wr_en = 1'b0; wr_lane_en = '0;
  endtask

  task automatic read_px(input logic [7:0] a, input logic [7:0] exp);
    set_read(a, exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic swap_now();
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    tb_front = ~tb_front;
  endtask

  // Wait (bounded) for all expected reads to come back, then confirm that
  // rd_valid has dropped and rd_data holds the last pixel.
  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_drain_left"}, 32'(sb_q.size()), 32'd0);
    check({tag, "_valid_low"}, 32'(rd_valid), 32'd0);
    check({tag, "_data_hold"}, 32'(rd_data), 32'(last_exp));
  endtask

  // Monitor: compare each presented pixel with the scoreboard head.
  always @(negedge clk) begin
    sb_t e;
    if (rst_n && rd_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_rd_valid", 32'(rd_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("read addr=%0d data=0x%02h expected=0x%02h cycle=%0d", e.addr, rd_data, e.data, cycle_cnt);
        check($sformatf("rd_data_a%0d", e.addr), 32'(rd_data), 32'(e.data));
        check($sformatf("rd_latency_a%0d", e.addr), 32'(cycle_cnt), 32'(e.edge_cyc + LAT - 1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    tb_front = 1'b0;
    last_exp = 8'h00;

    // Power-up reset (asynchronous assertion before any clock edge).
    #2 rst_n = 1'b0;
    #1;
    check("rst_front_bank", 32'(front_bank), 32'd0);
    check("rst_swap_pending", 32'(swap_pending), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Fill both banks with a known pattern; the swap in between is a
    // simultaneous swap_req + frame_start while IDLE.
    for (int w = 0; w < 64; w++) write_word(6'(w), 32'h01020304 * 32'(w + 1) + 32'h80808080, 4'hF);
    swap_now();
    $display("swap simultaneous front=%0d pending=%0d", front_bank, swap_pending);
    check("simul_swap_front", 32'(front_bank), 32'd1);
    check("simul_swap_pending", 32'(swap_pending), 32'd0);
    for (int w = 0; w < 64; w++) write_word(6'(w), 32'h04030201 * 32'(w + 1), 4'hF);

    // Lane order: bank 0 is back here.
    write_word(6'd5, 32'hDDCCBBAA, 4'hF);
    swap_now();
    check("lane_swap_front", 32'(front_bank), 32'd0);
    read_px(8'd20, 8'hAA);
    read_px(8'd21, 8'hBB);
    read_px(8'd22, 8'hCC);
    read_px(8'd23, 8'hDD);
    drain("lane_order");

    // Lane enables into bank 1, plus a wr_en with no lanes enabled.
    write_word(6'd5, 32'hDDCCBBAA, 4'hF);
    write_word(6'd5, 32'h11223344, 4'b0101);
    write_word(6'd5, 32'h55555555, 4'b0000);
    swap_now();
    check("lane_en_swap_front", 32'(front_bank), 32'd1);
    set_read(8'd20, 8'h44); tick();
    set_read(8'd21, 8'hBB); tick();
    set_read(8'd22, 8'h22); tick();
    set_read(8'd23, 8'hDD); tick();
    rd_en = 1'b0;
    drain("lane_enable");

    // Deferred swap.
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    $display("swap request front=%0d pending=%0d", front_bank, swap_pending);
    check("defer_pending_set", 32'(swap_pending), 32'd1);
    check("defer_front_kept", 32'(front_bank), 32'd1);
    repeat (40) tick();
    check("defer_pending_held", 32'(swap_pending), 32'd1);
    check("defer_front_held", 32'(front_bank), 32'd1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tb_front = 1'b0;
    $display("frame_start front=%0d pending=%0d", front_bank, swap_pending);
    check("defer_front_toggled", 32'(front_bank), 32'd0);
    check("defer_pending_clear", 32'(swap_pending), 32'd0);

    // Three requests merge into one toggle.
    for (int i = 0; i < 3; i++) begin
      swap_req = 1'b1; tick(); swap_req = 1'b0;
      repeat (2) tick();
    end
    check("multi_pending", 32'(swap_pending), 32'd1);
    check("multi_front_kept", 32'(front_bank), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    tb_front = 1'b1;
    check("multi_front_once", 32'(front_bank), 32'd1);
    check("multi_pending_clear", 32'(swap_pending), 32'd0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("multi_no_double", 32'(front_bank), 32'd1);

    // Isolation: fill the back bank with ones while scanning the front.
    for (int i = 0; i < 256; i++) begin
      set_write(6'(i % 64), 32'hFFFFFFFF, 4'hF);
      set_read(8'(i), model_px(8'(i)));
      tick();
    end
    idle_inputs();
    drain("isolation");

    // Read on the swap edge returns old-front data.
    set_read(8'd77, model_px(8'd77));
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    idle_inputs();
    tb_front = ~tb_front;
    check("edge_swap_front", 32'(front_bank), 32'd0);
    read_px(8'd77, 8'hFF);
    read_px(8'd21, 8'hFF);
    drain("swap_edge");

    // Reset mid-operation: pending swap plus an in-flight read.
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check("mid_pending_before", 32'(swap_pending), 32'd1);
    rd_en = 1'b1; rd_addr = 8'd20; tick(); rd_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    sb_q.delete();
    $display("mid-operation reset front=%0d pending=%0d valid=%0d data=0x%02h", front_bank, swap_pending, rd_valid, rd_data);
    check("mid_rst_front", 32'(front_bank), 32'd0);
    check("mid_rst_pending", 32'(swap_pending), 32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_data", 32'(rd_data), 32'd0);
    repeat (2) tick();
    check("mid_rst_valid_held", 32'(rd_valid), 32'd0);
    rst_n = 1'b1;
    tb_front = 1'b0;
    tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("mid_rst_swap_dropped", 32'(front_bank), 32'd0);
    read_px(8'd20, 8'hFF);
    read_px(8'd255, 8'hFF);
    drain("after_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_vga_dual_bank_ram
